// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS PC owner and req/ack instruction fetcher feeding decode; FETCH_PERF_CNT_EN adds perf counters
module instruction_fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_RESET = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [ADDR_WIDTH-1:0] pc_plus4_out,
   input  logic                  stall,
   input  logic                  jump,
   input  logic [25:0]           jump_index,
   input  logic                  branch_taken,
`ifdef FETCH_PERF_CNT_EN
   input  logic [ADDR_WIDTH-1:0] branch_offset,
   output logic [31:0]           perf_retired,
   output logic [31:0]           perf_stall
`else
   input  logic [ADDR_WIDTH-1:0] branch_offset
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} stateType;
   stateType state, nextState;
   logic capture, advance;
   logic [ADDR_WIDTH-1:0] nextPc;

   assign imem_addr = pc_out;
   assign pc_plus4_out = pc_out + ADDR_WIDTH'(4);
   assign nextPc = jump ? {pc_plus4_out[ADDR_WIDTH-1:28], jump_index, 2'b00}
                 : branch_taken ? pc_plus4_out + (branch_offset << 2) : pc_plus4_out;

   // next-state decode; the PC only advances out of an unstalled HOLD
   always_comb begin
      nextState = state;
      imem_req = 1'b0;
      capture = 1'b0;
      advance = 1'b0;
      case (state)
         IDLE: nextState = REQ;
         REQ: begin
            imem_req = 1'b1;
            capture = imem_ack;
            nextState = imem_ack ? HOLD : REQ;
         end
         HOLD: begin
            advance = !stall;
            nextState = stall ? HOLD : REQ;
         end
         default: nextState = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nextState;

   // PC and latched instruction
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pc_out <= PC_RESET;
         instr_out <= '0;
         instr_valid <= 1'b0;
      end else begin
         if (capture) begin
            instr_out <= imem_rdata;
            instr_valid <= 1'b1;
         end
         if (advance) begin
            pc_out <= nextPc;
            instr_valid <= 1'b0;
         end
      end

`ifdef FETCH_PERF_CNT_EN
   // retired-instruction and stall-cycle counters, free-running modulo 2^32
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         perf_retired <= '0;
         perf_stall <= '0;
      end else begin
         if (advance) perf_retired <= perf_retired + 32'd1;
         if (state == HOLD && stall) perf_stall <= perf_stall + 32'd1;
      end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic scored against a PC-sequence reference model
module tb_instruction_fetch_unit;
   localparam logic [31:0] PC_RESET = 32'h0040_0000;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} fetchT;

   logic clk = 1'b0, reset = 1'b0;
   logic imem_req, imem_ack = 1'b0, instr_valid;
   logic [31:0] imem_addr, imem_rdata = '0, instr_out, pc_out, pc_plus4_out;
   logic stall = 1'b0, jump = 1'b0, branch_taken = 1'b0;
   logic [25:0] jump_index = '0;
   logic [31:0] branch_offset = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_retired, perf_stall;
`endif

   int vecs = 0, errs = 0;
   fetchT expQ[$];
   logic [31:0] addrQ[$];
   logic [31:0] modelPc;

   instruction_fetch_unit #(.PC_RESET(PC_RESET)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
      .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
      .stall(stall), .jump(jump), .jump_index(jump_index), .branch_taken(branch_taken),
`ifdef FETCH_PERF_CNT_EN
      .branch_offset(branch_offset), .perf_retired(perf_retired), .perf_stall(perf_stall)
`else
      .branch_offset(branch_offset)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // architectural next-PC rule expressed with plain arithmetic
   function automatic logic [31:0] refNext(input logic [31:0] pc, input logic j, input logic [25:0] ji,
                                           input logic bt, input logic [31:0] bo);
      logic [31:0] seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) + {6'd0, ji} * 32'd4;
      if (bt) return seq + bo * 32'd4;
      return seq;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic waitReq;
      int n = 0;
      while (!imem_req && n < 20) begin
         tick;
         n++;
      end
      chk("req_timeout", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic fetch(input int lat, input int stalls, input logic j, input logic [25:0] ji,
                        input logic bt, input logic [31:0] bo);
      logic [31:0] data = $urandom;
      waitReq;
      repeat (lat) tick;
      imem_ack = 1'b1;
      imem_rdata = data;
      expQ.push_back('{modelPc, data});
      tick;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      repeat (stalls) begin
         stall = 1'b1;
         jump = 1'($urandom);
         jump_index = 26'($urandom);
         branch_taken = 1'($urandom);
         branch_offset = $urandom;
         tick;
      end
      stall = 1'b0;
      jump = j;
      jump_index = ji;
      branch_taken = bt;
      branch_offset = bo;
      modelPc = refNext(modelPc, j, ji, bt, bo);
      addrQ.push_back(modelPc);
      tick;
      stall = 1'($urandom);
      jump = 1'($urandom);
      jump_index = 26'($urandom);
      branch_taken = 1'($urandom);
      branch_offset = $urandom;
   endtask

   // monitor: request addresses and latched instructions against the scoreboard queues
   logic prevReq = 1'b0, prevValid = 1'b0;
   logic [31:0] curAddr = '0;
   fetchT cur;
   always @(negedge clk) begin
      if (!reset) begin
         prevReq = 1'b0;
         prevValid = 1'b0;
      end else begin
         if (imem_req && !prevReq) begin
            if (addrQ.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
            end else begin
               curAddr = addrQ.pop_front();
               chk("imem_addr", imem_addr, curAddr);
            end
         end else if (imem_req) chk("addr_stable", imem_addr, curAddr);
         if (instr_valid && !prevValid) begin
            if (expQ.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL unexpected_valid: got instr %h expected none", instr_out);
            end else begin
               cur = expQ.pop_front();
               chk("instr_out", instr_out, cur.instr);
               chk("pc_out", pc_out, cur.pc);
               chk("pc_plus4", pc_plus4_out, cur.pc + 32'd4);
            end
         end else if (instr_valid) begin
            chk("hold_instr", instr_out, cur.instr);
            chk("hold_pc", pc_out, cur.pc);
            chk("hold_no_req", {31'd0, imem_req}, 32'd0);
         end
         prevReq = imem_req;
         prevValid = instr_valid;
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", pc_out, PC_RESET);
      chk("rst_pc4", pc_plus4_out, PC_RESET + 32'd4);
      chk("rst_addr", imem_addr, PC_RESET);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr_out, 32'd0);
      modelPc = PC_RESET;
      addrQ.push_back(PC_RESET);
      reset = 1'b1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      tick;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      fetch(0, 0, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(2, 0, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(1, 1, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFE);
      fetch(0, 0, 1'b0, 26'd0, 1'b1, 32'd2);
      fetch(3, 5, 1'b1, 26'h010_0003, 1'b1, 32'd5);
      fetch(0, 0, 1'b0, 26'd0, 1'b1, (32'hFFFF_FFFC - 32'h0040_0010) >> 2);
      fetch(1, 0, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(0, 2, 1'b0, 26'd0, 1'b0, 32'd0);
      for (int i = 0; i < 150; i++)
         fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
               26'($urandom), 1'($urandom), $urandom);
      waitReq;
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_req", {31'd0, imem_req}, 32'd0);
      chk("async_rst_pc", pc_out, PC_RESET);
      chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      modelPc = PC_RESET;
      addrQ.delete();
      addrQ.push_back(PC_RESET);
      tick;
      tick;
      reset = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      tick;
      imem_ack = 1'b0;
      chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("restart_req", {31'd0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, PC_RESET);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_retired_rst", perf_retired, 32'd0);
      chk("perf_stall_rst", perf_stall, 32'd0);
`endif
      fetch(0, 1, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(2, 0, 1'b0, 26'd0, 1'b0, 32'd0);
      repeat (3) tick;
      chk("expq_drained", 32'(expQ.size()), 32'd0);
      chk("addrq_drained", 32'(addrQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
